bcd_cnt_chain: RTL and testbench
================================

# bcd_cnt_chain

Parametrised multi-digit BCD counter for the music player's numeric displays: track number, volume step and elapsed-time fields. Each 4-bit digit rolls over 0-9 and carries into the next digit. The counter adds an upper limit, wrap or saturate behaviour, parallel load, a registered wrap pulse and optional down-counting. It sits between the button debouncers and the seven-segment display mux.

## Interface
Parameters:
- DIGITS, 2: number of BCD digits (1..8).
- MAX_VAL, {DIGITS{4'h9}}: BCD-encoded upper limit; every digit must be ≤9.
- WRAP, 1: 1 = wrap at the limits; 0 = saturate at the limits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ena  in  1  count enable; gates inc and dec only
- inc  in  1  increment request, one step per cycle while high
- dec  in  1  decrement request; used only with CNT_DOWN_EN
- load  in  1  parallel load; works regardless of ena
- load_val  in  4*DIGITS  BCD value to load
- count  out  4*DIGITS  registered BCD count, digit 0 in bits [3:0]
- wrap_pulse  out  1  registered; high for one cycle after a wrap
- at_max  out  1  combinational, count == MAX_VAL
- at_min  out  1  combinational, count == 0

## Operation
- Priority on each rising edge: rst, then load, then counting.
- rst:
  - count ← 0
  - wrap_pulse ← 0
- load:
  - count ← load_val when every digit is ≤9 and load_val ≤ MAX_VAL.
  - Otherwise count ← MAX_VAL (clamp).
  - wrap_pulse ← 0.
- Counting happens only when ena=1.
  - inc=1, dec=0: count+1 in BCD. Digit i increments when all lower digits are 9; those lower digits go to 0.
  - inc=0, dec=1: count−1 in BCD. Digit i decrements when all lower digits are 0; those lower digits go to 9.
  - inc=1, dec=1: hold. Same for inc=dec=0.
- Upper limit, increment at count==MAX_VAL:
  - WRAP=1: count ← 0, wrap_pulse ← 1.
  - WRAP=0: hold, wrap_pulse ← 0.
- Lower limit, decrement at count==0:
  - WRAP=1: count ← MAX_VAL, wrap_pulse ← 1.
  - WRAP=0: hold.
- wrap_pulse is 0 on every edge that does not wrap.
- Comparisons against MAX_VAL are plain unsigned compares on the BCD vector; they are valid because all digits are valid BCD.
- The count never holds a digit >9 and never exceeds MAX_VAL.

## Timing
- Latency: one clock from inc, dec, load or rst to the new count.
- wrap_pulse rises on the same edge the count wraps and stays high for exactly one cycle.
- Holding inc high wraps once every MAX_VAL+1 cycles; wrap_pulse is high on each wrap edge.
- at_max and at_min follow count combinationally. After reset, at_min=1 and at_max=0; at_max=1 only when MAX_VAL==0.
- rst mid-count clears count and wrap_pulse on the next edge, overriding a simultaneous load, inc or dec.
- load while ena=0 still takes effect.

## Configuration
- CNT_DOWN_EN defined:
  - The dec path, lower-limit wrap and inc/dec conflict hold are compiled in.
- CNT_DOWN_EN undefined:
  - dec is ignored; the port remains, but no decrement logic is generated.
  - inc=1 with dec=1 increments.
  - at_min is still generated.

## Structure
- Shared package cnt_pkg:
  - typedef bcd_digit_t (4-bit)
  - constants BCD_MAX = 4'd9 and BCD_MIN = 4'd0
  - function bcd_valid(vector, digits): returns 1 when every digit is ≤9
- Sub-module bcd_digit:
  - One digit register with cin/bin in and cout/bout out.
  - cout=1 when the digit is 9 and cin=1; bout=1 when the digit is 0 and bin=1.
  - The top level instantiates DIGITS of them in a generate loop and chains the carries.
  - Limit detection, wrap handling and load clamp are in the top level.

## Test plan
1. DIGITS=2, MAX_VAL=8'h99, WRAP=1. Reset, then inc held for 100 cycles: count goes 00→09→10→…→99→00; wrap_pulse is high for exactly one cycle, on the 99→00 edge.
2. MAX_VAL=8'h12, WRAP=0. Load 8'h10, then inc for 5 cycles: count goes 10, 11, 12, 12, 12; at_max=1 from the third cycle; wrap_pulse stays 0.
3. CNT_DOWN_EN defined, MAX_VAL=8'h12, WRAP=1. Load 8'h01, then dec for 3 cycles: count goes 00, 12, 11; wrap_pulse is high only on the 00→12 edge.
4. Load 8'h3A (invalid digit), then load 8'h50 (above MAX_VAL=8'h12): count=8'h12 after each load; loading 8'h07 with ena=0 gives 07.
5. rst asserted together with load=1 and inc=1 while count=8'h11: next count is 00 and wrap_pulse=0.
6. inc=dec=1 with ena=1 at count=8'h05: holds 05 with CNT_DOWN_EN defined; goes to 06 without it.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared BCD types, digit limits and a validity helper for the BCD counter chain.
package cnt_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Vector is zero-extended to 8 digits; only the low `digits` nibbles are inspected.
    function automatic logic bcd_valid(input logic [31:0] vec, input int unsigned digits);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < digits && vec[4*i +: 4] > BCD_MAX) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with carry (cin/cout) and borrow (bin/bout) chaining.
module bcd_digit
    import cnt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ld,
    input  bcd_digit_t i_ld_val,
    input  logic       i_cin,
    input  logic       i_bin,
    output bcd_digit_t o_q,
    output logic       o_cout,
    output logic       o_bout
);

    bcd_digit_t r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= BCD_MIN;
        end else if (i_ld) begin
            r_q <= i_ld_val;
        end else if (i_cin) begin
            r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
        end else if (i_bin) begin
            r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
        end
    end

    assign o_q    = r_q;
    assign o_cout = i_cin & (r_q == BCD_MAX);
    assign o_bout = i_bin & (r_q == BCD_MIN);

endmodule

// File: rtl/bcd_cnt_chain.sv
// Multi-digit BCD counter with limit, wrap/saturate, clamped load and wrap pulse.
// Define CNT_DOWN_EN to compile in the decrement path and inc/dec conflict hold.
module bcd_cnt_chain
    import cnt_pkg::*;
#(
    parameter int unsigned         DIGITS  = 2,
    parameter logic [4*DIGITS-1:0] MAX_VAL = {DIGITS{4'h9}},
    parameter bit                  WRAP    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap_pulse,
    output logic                  at_max,
    output logic                  at_min
);

    logic [4*DIGITS-1:0] w_count;
    logic [4*DIGITS-1:0] w_ld_val;
    logic [4*DIGITS-1:0] w_load_clamped;
    logic [DIGITS:0]     w_carry;
    logic [DIGITS:0]     w_borrow;
    logic                w_up;
    logic                w_dn;
    logic                w_at_max;
    logic                w_at_min;
    logic                w_inc_wrap;
    logic                w_dec_wrap;
    logic                w_load_ok;
    logic                w_ld;
    logic                w_unused;
    logic                r_wrap_pulse;

`ifdef CNT_DOWN_EN
    assign w_up     = ena & inc & ~dec;
    assign w_dn     = ena & dec & ~inc;
    assign w_unused = ^{w_carry[DIGITS], w_borrow[DIGITS]};
`else
    assign w_up     = ena & inc;
    assign w_dn     = 1'b0;
    assign w_unused = ^{w_carry[DIGITS], w_borrow[DIGITS], dec};
`endif

    assign w_at_max   = (w_count == MAX_VAL);
    assign w_at_min   = (w_count == '0);
    assign w_inc_wrap = w_up & w_at_max & WRAP;
    assign w_dec_wrap = w_dn & w_at_min & WRAP;

    // Invalid or out-of-range loads clamp to the limit so the count stays legal.
    assign w_load_ok      = bcd_valid(32'(load_val), DIGITS) && (load_val <= MAX_VAL);
    assign w_load_clamped = w_load_ok ? load_val : MAX_VAL;

    // Wraps reuse the parallel-load path; ordinary steps ripple through the chain.
    assign w_ld       = load | w_inc_wrap | w_dec_wrap;
    assign w_ld_val   = load ? w_load_clamped : (w_dec_wrap ? MAX_VAL : '0);
    assign w_carry[0] = ~load & w_up & ~w_at_max;
    assign w_borrow[0] = ~load & w_dn & ~w_at_min;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .i_ld     (w_ld),
            .i_ld_val (w_ld_val[4*g +: 4]),
            .i_cin    (w_carry[g]),
            .i_bin    (w_borrow[g]),
            .o_q      (w_count[4*g +: 4]),
            .o_cout   (w_carry[g+1]),
            .o_bout   (w_borrow[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap_pulse <= 1'b0;
        end else begin
            r_wrap_pulse <= ~load & (w_inc_wrap | w_dec_wrap);
        end
    end

    assign count      = w_count;
    assign wrap_pulse = r_wrap_pulse;
    assign at_max     = w_at_max;
    assign at_min     = w_at_min;

endmodule

// File: tb/tb_bcd_cnt_chain.sv
// Bench for bcd_cnt_chain: three instances (wrap 99, saturate 12, wrap 12) driven in lockstep.
module tb_bcd_cnt_chain;

`ifdef CNT_DOWN_EN
    localparam bit DOWN = 1'b1;
`else
    localparam bit DOWN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, ena, inc, dec, load;
    logic [7:0] load_val;

    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic       wp_a, wp_b, wp_c, mx_a, mx_b, mx_c, mn_a, mn_b, mn_c;
    logic [10:0] obs [3];

    int total = 0;
    int bad   = 0;

    int m_cnt [3];
    bit m_wp  [3];
    int maxv  [3] = '{99, 12, 12};
    bit wrapv [3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    bcd_cnt_chain #(.DIGITS(2), .MAX_VAL(8'h99), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val), .count(cnt_a), .wrap_pulse(wp_a), .at_max(mx_a), .at_min(mn_a)
    );
    bcd_cnt_chain #(.DIGITS(2), .MAX_VAL(8'h12), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val), .count(cnt_b), .wrap_pulse(wp_b), .at_max(mx_b), .at_min(mn_b)
    );
    bcd_cnt_chain #(.DIGITS(2), .MAX_VAL(8'h12), .WRAP(1'b1)) dut_c (
        .clk(clk), .rst(rst), .ena(ena), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val), .count(cnt_c), .wrap_pulse(wp_c), .at_max(mx_c), .at_min(mn_c)
    );

    assign obs[0] = {cnt_a, wp_a, mx_a, mn_a};
    assign obs[1] = {cnt_b, wp_b, mx_b, mn_b};
    assign obs[2] = {cnt_c, wp_c, mx_c, mn_c};

    function automatic logic [7:0] int2bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (count,wrap,max,min)", name, act, exp);
        end
    endtask

    // Reference model works on plain integers, not on BCD digits.
    task automatic model_step();
        bit up, dn, valid;
        int v;
        up = ena && inc && !(DOWN && dec);
        dn = DOWN && ena && dec && !inc;
        for (int d = 0; d < 3; d++) begin
            m_wp[d] = 1'b0;
            if (rst) begin
                m_cnt[d] = 0;
            end else if (load) begin
                valid = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
                v = int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
                m_cnt[d] = (!valid || v > maxv[d]) ? maxv[d] : v;
            end else if (up) begin
                if (m_cnt[d] < maxv[d]) m_cnt[d]++;
                else if (wrapv[d]) begin m_cnt[d] = 0; m_wp[d] = 1'b1; end
            end else if (dn) begin
                if (m_cnt[d] > 0) m_cnt[d]--;
                else if (wrapv[d]) begin m_cnt[d] = maxv[d]; m_wp[d] = 1'b1; end
            end
        end
    endtask

    task automatic tick(input string name);
        @(posedge clk);
        model_step();
        #1;
        for (int d = 0; d < 3; d++) begin
            check(name, obs[d], {int2bcd(m_cnt[d]), m_wp[d], m_cnt[d] == maxv[d],
                                 m_cnt[d] == 0});
        end
    endtask

    task automatic drive(input bit r, input bit l, input logic [7:0] lv,
                         input bit e, input bit i, input bit dd);
        rst = r; load = l; load_val = lv; ena = e; inc = i; dec = dd;
    endtask

    typedef struct {
        bit         rst;
        bit         load;
        logic [7:0] lv;
        bit         ena;
        bit         inc;
        logic [7:0] exp_b;
    } vec_t;

    vec_t tbl [16];
    int   pulses;
    logic [7:0] exp_c [3];
    bit         exp_cw [3];

    initial begin
        // Expected counts for the saturating MAX=12 instance after each edge.
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h10};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h12};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h12};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h12};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 1'b1, 8'h3A, 1'b0, 1'b0, 8'h12};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 1'b1, 8'h50, 1'b0, 1'b0, 8'h12};
        tbl[10] = '{1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 8'h07};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h07};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h08};
        tbl[13] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h11};
        tbl[14] = '{1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 8'h00};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01};

        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick("reset");
        check("reset_a", obs[0], {8'h00, 1'b0, 1'b0, 1'b1});

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].load, tbl[k].lv, tbl[k].ena, tbl[k].inc, 1'b0);
            tick("table_all");
            check($sformatf("table_b[%0d]", k), obs[1],
                  {tbl[k].exp_b, 1'b0, tbl[k].exp_b == 8'h12, tbl[k].exp_b == 8'h00});
        end

        // Full 00..99 run with inc held: exactly one pulse, on the 99->00 edge.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick("p1_reset");
        pulses = 0;
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 100; k++) begin
            tick("p1_model");
            if (wp_a) pulses++;
            check($sformatf("p1_step[%0d]", k), {cnt_a, wp_a, 2'b00},
                  {int2bcd(k % 100), k == 100, 2'b00});
        end
        check("p1_pulse_count", 11'(pulses), 11'd1);

        // Decrement through the lower limit on the wrapping MAX=12 instance.
        drive(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        tick("p3_load");
`ifdef CNT_DOWN_EN
        exp_c = '{8'h00, 8'h12, 8'h11};
        exp_cw = '{1'b0, 1'b1, 1'b0};
`else
        exp_c = '{8'h01, 8'h01, 8'h01};
        exp_cw = '{1'b0, 1'b0, 1'b0};
`endif
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick("p3_model");
            check($sformatf("p3_dec[%0d]", k), {cnt_c, wp_c, 2'b00}, {exp_c[k], exp_cw[k], 2'b00});
        end

        // inc and dec together.
        drive(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
        tick("p6_load");
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        tick("p6_model");
        check("p6_conflict", {cnt_b, 3'b000}, {DOWN ? 8'h05 : 8'h06, 3'b000});

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, 8'($urandom),
                  $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
